// File: rtl/fpu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fpu_result_fifo
// Brief    : Result buffer behind the FPU output mux. Overflow is sticky and
//            flags results dropped while the buffer is full.
//            Optional FPU_RESULT_FIFO_STATS_EN adds push/drop counters.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_result_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] In_Data,
    input  logic              In_Data_Valid,
    output logic [DATA_W-1:0] Out_Data,
    output logic              Out_Data_Valid,
    input  logic              Out_Ready,
    output logic              Full,
    output logic              Empty,
    output logic [ADDR_W:0]   Count,
`ifdef FPU_RESULT_FIFO_STATS_EN
    output logic [15:0]       Push_Count,
    output logic [15:0]       Drop_Count,
`endif
    output logic              Overflow
);

    localparam logic [DATA_W-1:0] c_IDLE_DATA = '1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic              r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // Status comes only from registered pointers, never from In_Data_Valid.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]) &&
                     (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]);
    assign w_pop   = !w_empty && Out_Ready;
    assign w_push  = In_Data_Valid && (!w_full || w_pop);
    assign w_drop  = In_Data_Valid && w_full && !w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= In_Data;
        end
    end

    assign Out_Data       = w_empty ? c_IDLE_DATA : r_mem[r_rd_ptr[ADDR_W-1:0]];
    assign Out_Data_Valid = !w_empty;
    assign Empty          = w_empty;
    assign Full           = w_full;
    assign Count          = r_wr_ptr - r_rd_ptr;
    assign Overflow       = r_overflow;

`ifdef FPU_RESULT_FIFO_STATS_EN
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [15:0] r_push_count;
    logic [15:0] r_drop_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_push_count <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_push && (r_push_count != c_CNT_MAX)) begin
                r_push_count <= r_push_count + 16'd1;
            end
            if (w_drop && (r_drop_count != c_CNT_MAX)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign Push_Count = r_push_count;
    assign Drop_Count = r_drop_count;
`endif

endmodule
`default_nettype wire
